// File: rtl/condlogic_it_if.sv
// Decoder/datapath control bundle for condlogic_it.
// master: decoder side (drives controls, observes gated results)
// slave : the conditional-execution unit
interface condlogic_it_if #(
   parameter int NBANKS = 2,
   parameter int IT_MAX = 4
);
   localparam int BSEL_W = (NBANKS > 1) ? $clog2(NBANKS) : 1;
   localparam int CNT_W  = $clog2(IT_MAX + 1);

   // decoder controls
   logic              en;
   logic [3:0]        Cond;
   logic [3:0]        ALUFlags;
   logic [1:0]        FlagW;
   logic              PCS;
   logic              RegW;
   logic              MemW;
   logic              NoWrite;
   logic [BSEL_W-1:0] BankSel;
   logic              ITStart;
   logic [3:0]        ITCond;
   logic [CNT_W-1:0]  ITCount;
   logic [IT_MAX-1:0] ITPattern;

   // gated results
   logic              PCSrc;
   logic              RegWrite;
   logic              MemWrite;
   logic              CondEx;
   logic [3:0]        Flags;
   logic              ITActive;
   logic [CNT_W-1:0]  ITRemain;

   modport master (
      output en, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, BankSel,
             ITStart, ITCond, ITCount, ITPattern,
      input  PCSrc, RegWrite, MemWrite, CondEx, Flags, ITActive, ITRemain
   );

   modport slave (
      input  en, Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite, BankSel,
             ITStart, ITCond, ITCount, ITPattern,
      output PCSrc, RegWrite, MemWrite, CondEx, Flags, ITActive, ITRemain
   );
endinterface

// File: rtl/condlogic_it.sv
// condlogic_it: conditional-execution unit between decoder and datapath
// write enables. Banked NZCV flags, condition evaluation and an optional
// If-Then sequencer, built only when CONDLOGIC_IT_EN is defined; without
// it the IT inputs are ignored and ITActive/ITRemain read 0.
module condlogic_it #(
   parameter int         NBANKS     = 2,
   parameter int         IT_MAX     = 4,
   parameter logic [3:0] FLAG_RESET = 4'b0000
) (
   input logic           clk,
   input logic           reset,
   condlogic_it_if.slave bus
);
   localparam int CNT_W = $clog2(IT_MAX + 1);

   // condition field evaluated against {N,Z,C,V}
   function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cf, v, r;
      {n, z, cf, v} = f;
      r = 1'b1;
      case (c)
         4'h0:    r = z;
         4'h1:    r = ~z;
         4'h2:    r = cf;
         4'h3:    r = ~cf;
         4'h4:    r = n;
         4'h5:    r = ~n;
         4'h6:    r = v;
         4'h7:    r = ~v;
         4'h8:    r = cf & ~z;
         4'h9:    r = ~cf | z;
         4'hA:    r = (n == v);
         4'hB:    r = (n != v);
         4'hC:    r = ~z & (n == v);
         4'hD:    r = z | (n != v);
         default: r = 1'b1;
      endcase
      return r;
   endfunction

   logic [3:0] flags_r [NBANKS];
   logic [3:0] cur_flags_s;
   logic [3:0] eff_cond_s;
   logic       suppress_s;
   logic       cond_ex_s;
   logic       gate_s;
   logic       pcsrc_s;

   // Read mux for the addressed bank; unmapped bank numbers read as reset value
   always_comb begin
      cur_flags_s = FLAG_RESET;
      for (int b = 0; b < NBANKS; b++) begin
         cur_flags_s = (int'(bus.BankSel) == b) ? flags_r[b] : cur_flags_s;
      end
   end

   // Same-cycle gating; reset low forces every enable low
   always_comb begin
      cond_ex_s = reset & bus.en & cond_eval(eff_cond_s, cur_flags_s);
      gate_s    = cond_ex_s & ~suppress_s;
      pcsrc_s   = gate_s & bus.PCS;
   end

   assign bus.CondEx   = cond_ex_s;
   assign bus.PCSrc    = pcsrc_s;
   assign bus.RegWrite = gate_s & bus.RegW & ~bus.NoWrite;
   assign bus.MemWrite = gate_s & bus.MemW;
   assign bus.Flags    = cur_flags_s;

   // Banked flag storage: only a passing, unsuppressed instruction writes,
   // and out-of-range bank numbers match no bank so their writes vanish
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int b = 0; b < NBANKS; b++) begin
            flags_r[b] <= FLAG_RESET;
         end
      end else begin
         for (int b = 0; b < NBANKS; b++) begin
            if (gate_s && (int'(bus.BankSel) == b)) begin
               if (bus.FlagW[1]) begin
                  flags_r[b][3:2] <= bus.ALUFlags[3:2];
               end
               if (bus.FlagW[0]) begin
                  flags_r[b][1:0] <= bus.ALUFlags[1:0];
               end
            end
         end
      end
   end

`ifdef CONDLOGIC_IT_EN
   typedef enum logic {IT_IDLE = 1'b0, IT_ACTIVE = 1'b1} it_state_t;

   it_state_t         state_r, state_nx;
   logic [3:0]        itcond_r, itcond_nx;
   logic [IT_MAX-1:0] itpat_r, itpat_nx;
   logic [CNT_W-1:0]  remain_r, remain_nx;
   logic [CNT_W-1:0]  idx_r, idx_nx;
   logic              start_ok_s;
   logic              slot_then_s;

   // An IT instruction only counts when its length is in 1..IT_MAX
   assign start_ok_s = bus.en & bus.ITStart & (bus.ITCount != CNT_W'(0))
                       & (int'(bus.ITCount) <= IT_MAX);

   // Pattern bit of the current slot (loop avoids an over-wide index)
   always_comb begin
      slot_then_s = 1'b0;
      for (int i = 0; i < IT_MAX; i++) begin
         slot_then_s = (idx_r == CNT_W'(i)) ? itpat_r[i] : slot_then_s;
      end
   end

   // Inside a block the slot condition replaces Cond; the IT instruction
   // itself is still judged on its own Cond but cannot write anything
   always_comb begin
      if ((state_r == IT_ACTIVE) && !start_ok_s) begin
         eff_cond_s = slot_then_s ? itcond_r : (itcond_r ^ 4'b0001);
      end else begin
         eff_cond_s = bus.Cond;
      end
      suppress_s = start_ok_s;
   end

   // IT sequencer next state: start/abort, slot consumption, branch flush
   always_comb begin
      state_nx  = state_r;
      itcond_nx = itcond_r;
      itpat_nx  = itpat_r;
      remain_nx = remain_r;
      idx_nx    = idx_r;
      if (start_ok_s) begin
         state_nx  = IT_ACTIVE;
         itcond_nx = bus.ITCond;
         itpat_nx  = bus.ITPattern;
         remain_nx = bus.ITCount;
         idx_nx    = CNT_W'(0);
      end else begin
         case (state_r)
            IT_IDLE: begin
               state_nx = IT_IDLE;
            end
            IT_ACTIVE: begin
               if (!bus.en) begin
                  state_nx = IT_ACTIVE;
               end else if (pcsrc_s || (remain_r <= CNT_W'(1))) begin
                  state_nx  = IT_IDLE;
                  remain_nx = CNT_W'(0);
                  idx_nx    = CNT_W'(0);
               end else begin
                  remain_nx = remain_r - CNT_W'(1);
                  idx_nx    = idx_r + CNT_W'(1);
               end
            end
            default: begin
               state_nx  = IT_IDLE;
               remain_nx = CNT_W'(0);
               idx_nx    = CNT_W'(0);
            end
         endcase
      end
   end

   // IT sequencer state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r  <= IT_IDLE;
         itcond_r <= 4'b0000;
         itpat_r  <= {IT_MAX{1'b0}};
         remain_r <= CNT_W'(0);
         idx_r    <= CNT_W'(0);
      end else begin
         state_r  <= state_nx;
         itcond_r <= itcond_nx;
         itpat_r  <= itpat_nx;
         remain_r <= remain_nx;
         idx_r    <= idx_nx;
      end
   end

   assign bus.ITActive = (state_r == IT_ACTIVE);
   assign bus.ITRemain = remain_r;
`else
   logic unused_it_s;
   assign unused_it_s  = ^{bus.ITStart, bus.ITCond, bus.ITCount, bus.ITPattern};
   assign eff_cond_s   = bus.Cond;
   assign suppress_s   = 1'b0;
   assign bus.ITActive = 1'b0;
   assign bus.ITRemain = CNT_W'(0);
`endif
endmodule

// File: tb/tb_condlogic_it.sv
// Bench for condlogic_it: literal vector table, hand-written IT sequences,
// random stimulus against a queue-based reference model, mid-cycle reset.
module tb_condlogic_it;
   localparam int NB  = 3;
   localparam int ITM = 4;
`ifdef CONDLOGIC_IT_EN
   localparam bit IT_ON = 1'b1;
`else
   localparam bit IT_ON = 1'b0;
`endif

   typedef struct {
      bit         en;
      logic [3:0] cond;
      logic [3:0] alu;
      logic [1:0] fw;
      bit         pcs, regw, memw, nowr;
      logic [1:0] bsel;
      bit         its;
      logic [3:0] itc;
      logic [2:0] itn;
      logic [3:0] itp;
   } in_t;

   typedef struct {
      in_t        i;
      bit         ex, rw, mw, pc;
      logic [3:0] fl;
   } vec_t;

   logic clk = 1'b0;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   condlogic_it_if #(.NBANKS(NB), .IT_MAX(ITM)) bus ();

   condlogic_it #(.NBANKS(NB), .IT_MAX(ITM), .FLAG_RESET(4'b0000)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );

   // reference model state
   logic [3:0] bank_m [NB];
   logic [3:0] slot_q [$];

   // sampled DUT outputs of the last step
   int s_ex, s_rw, s_mw, s_pc, s_fl, s_act, s_rem;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // pairs of conditions are complements; 14/15 always pass
   function automatic bit mod_eval(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cf, v, r;
      n = f[3]; z = f[2]; cf = f[1]; v = f[0];
      case (c[3:1])
         3'd0: r = z;
         3'd1: r = cf;
         3'd2: r = n;
         3'd3: r = v;
         3'd4: r = cf & ~z;
         3'd5: r = (n == v);
         3'd6: r = ~z & (n == v);
         default: r = 1'b1;
      endcase
      if (c[3:1] != 3'd7 && c[0]) r = ~r;
      return r;
   endfunction

   function automatic in_t idle_in();
      in_t v;
      v.en = 1'b1; v.cond = 4'hE; v.alu = 4'h0; v.fw = 2'b00;
      v.pcs = 1'b0; v.regw = 1'b0; v.memw = 1'b0; v.nowr = 1'b0;
      v.bsel = 2'd0; v.its = 1'b0; v.itc = 4'h0; v.itn = 3'd0; v.itp = 4'h0;
      return v;
   endfunction

   function automatic vec_t mk(input bit en, input logic [3:0] cond, input logic [3:0] alu,
                               input logic [1:0] fw, input bit pcs, input bit regw,
                               input bit memw, input bit nowr, input logic [1:0] bsel,
                               input bit ex, input bit rw, input bit mw, input bit pc,
                               input logic [3:0] fl);
      vec_t t;
      t.i = idle_in();
      t.i.en = en; t.i.cond = cond; t.i.alu = alu; t.i.fw = fw; t.i.pcs = pcs;
      t.i.regw = regw; t.i.memw = memw; t.i.nowr = nowr; t.i.bsel = bsel;
      t.ex = ex; t.rw = rw; t.mw = mw; t.pc = pc; t.fl = fl;
      return t;
   endfunction

   task automatic drive(input in_t v);
      bus.en = v.en; bus.Cond = v.cond; bus.ALUFlags = v.alu; bus.FlagW = v.fw;
      bus.PCS = v.pcs; bus.RegW = v.regw; bus.MemW = v.memw; bus.NoWrite = v.nowr;
      bus.BankSel = v.bsel; bus.ITStart = v.its; bus.ITCond = v.itc;
      bus.ITCount = v.itn; bus.ITPattern = v.itp;
   endtask

   task automatic model_reset();
      for (int b = 0; b < NB; b++) bank_m[b] = 4'b0000;
      slot_q.delete();
   endtask

   // apply one instruction, compare against the model, clock, update model
   task automatic step(input in_t v);
      logic [3:0] fl, eff;
      bit start, ex, g;
      drive(v);
      @(negedge clk);
      fl    = (int'(v.bsel) < NB) ? bank_m[v.bsel] : 4'b0000;
      start = IT_ON && v.en && v.its && (v.itn >= 3'd1) && (int'(v.itn) <= ITM);
      eff   = (slot_q.size() != 0 && !start) ? slot_q[0] : v.cond;
      ex    = v.en && mod_eval(eff, fl);
      g     = ex && !start;
      s_ex = int'(bus.CondEx); s_rw = int'(bus.RegWrite); s_mw = int'(bus.MemWrite);
      s_pc = int'(bus.PCSrc); s_fl = int'(bus.Flags); s_act = int'(bus.ITActive);
      s_rem = int'(bus.ITRemain);
      chk("condex", s_ex, int'(ex));
      chk("regwrite", s_rw, int'(g && v.regw && !v.nowr));
      chk("memwrite", s_mw, int'(g && v.memw));
      chk("pcsrc", s_pc, int'(g && v.pcs));
      chk("flags", s_fl, int'(fl));
      chk("itactive", s_act, int'(slot_q.size() != 0));
      chk("itremain", s_rem, slot_q.size());
      @(posedge clk);
      if (v.en) begin
         if (g && int'(v.bsel) < NB) begin
            if (v.fw[1]) bank_m[v.bsel][3:2] = v.alu[3:2];
            if (v.fw[0]) bank_m[v.bsel][1:0] = v.alu[1:0];
         end
         if (start) begin
            slot_q.delete();
            for (int k = 0; k < int'(v.itn); k++)
               slot_q.push_back(v.itp[k] ? v.itc : (v.itc ^ 4'b0001));
         end else if (slot_q.size() != 0) begin
            if (g && v.pcs) slot_q.delete();
            else void'(slot_q.pop_front());
         end
      end
      #1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t tbl [$];
      in_t  v, s;

      tbl.push_back(mk(1, 4'h0, 4'h0, 2'b00, 0, 1, 0, 0, 2'd0, 0, 0, 0, 0, 4'b0000));
      tbl.push_back(mk(1, 4'hE, 4'h4, 2'b10, 0, 1, 0, 0, 2'd0, 1, 1, 0, 0, 4'b0000));
      tbl.push_back(mk(1, 4'hE, 4'hB, 2'b01, 0, 0, 0, 0, 2'd0, 1, 0, 0, 0, 4'b0100));
      tbl.push_back(mk(1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 2'd0, 1, 0, 0, 0, 4'b0111));
      tbl.push_back(mk(1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 2'd1, 1, 0, 0, 0, 4'b0000));
      tbl.push_back(mk(1, 4'h1, 4'hF, 2'b11, 0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 4'b0111));
      tbl.push_back(mk(1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 2'd0, 1, 0, 0, 0, 4'b0111));
      tbl.push_back(mk(1, 4'hE, 4'hF, 2'b11, 0, 1, 0, 0, 2'd3, 1, 1, 0, 0, 4'b0000));
      tbl.push_back(mk(1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 2'd3, 1, 0, 0, 0, 4'b0000));
      tbl.push_back(mk(1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 2'd2, 1, 0, 0, 0, 4'b0000));
      tbl.push_back(mk(1, 4'hE, 4'h0, 2'b00, 0, 0, 0, 0, 2'd1, 1, 0, 0, 0, 4'b0000));
      tbl.push_back(mk(0, 4'hE, 4'hF, 2'b11, 0, 1, 0, 0, 2'd0, 0, 0, 0, 0, 4'b0111));
      tbl.push_back(mk(1, 4'h0, 4'h0, 2'b00, 1, 1, 1, 1, 2'd0, 1, 0, 1, 1, 4'b0111));
      tbl.push_back(mk(1, 4'hC, 4'h0, 2'b00, 0, 1, 0, 0, 2'd0, 0, 0, 0, 0, 4'b0111));
      tbl.push_back(mk(1, 4'h8, 4'h0, 2'b00, 0, 1, 0, 0, 2'd0, 0, 0, 0, 0, 4'b0111));
      tbl.push_back(mk(1, 4'h9, 4'h0, 2'b00, 0, 1, 0, 0, 2'd0, 1, 1, 0, 0, 4'b0111));
      tbl.push_back(mk(1, 4'hA, 4'h0, 2'b00, 0, 0, 1, 0, 2'd0, 0, 0, 0, 0, 4'b0111));
      tbl.push_back(mk(1, 4'hB, 4'h0, 2'b00, 0, 0, 1, 0, 2'd0, 1, 0, 1, 0, 4'b0111));
      tbl.push_back(mk(1, 4'h2, 4'h0, 2'b00, 0, 1, 0, 0, 2'd0, 1, 1, 0, 0, 4'b0111));
      tbl.push_back(mk(1, 4'h3, 4'h0, 2'b00, 0, 1, 0, 0, 2'd0, 0, 0, 0, 0, 4'b0111));

      // reset held: everything forced low
      reset = 1'b0;
      v = idle_in(); v.regw = 1'b1; v.memw = 1'b1; v.pcs = 1'b1;
      drive(v);
      model_reset();
      #12;
      chk("rst_condex", int'(bus.CondEx), 0);
      chk("rst_regwrite", int'(bus.RegWrite), 0);
      chk("rst_pcsrc", int'(bus.PCSrc), 0);
      chk("rst_flags", int'(bus.Flags), 0);
      chk("rst_itremain", int'(bus.ITRemain), 0);
      @(posedge clk); #1;
      reset = 1'b1;

      // literal vector table
      for (int k = 0; k < tbl.size(); k++) begin
         step(tbl[k].i);
         chk($sformatf("tbl%0d_condex", k), s_ex, int'(tbl[k].ex));
         chk($sformatf("tbl%0d_regwrite", k), s_rw, int'(tbl[k].rw));
         chk($sformatf("tbl%0d_memwrite", k), s_mw, int'(tbl[k].mw));
         chk($sformatf("tbl%0d_pcsrc", k), s_pc, int'(tbl[k].pc));
         chk($sformatf("tbl%0d_flags", k), s_fl, int'(tbl[k].fl));
      end

      // IT block EQ x3, pattern 0101, Z=1: pass/fail/pass, with a stall
      s = idle_in(); s.regw = 1'b1;
      v = s; v.its = 1'b1; v.itc = 4'h0; v.itn = 3'd3; v.itp = 4'b0101;
      step(v);
      chk("it_start_condex", s_ex, 1);
      chk("it_start_regwrite", s_rw, IT_ON ? 0 : 1);
      step(s);
      chk("it_slot0_condex", s_ex, 1);
      chk("it_slot0_remain", s_rem, IT_ON ? 3 : 0);
      chk("it_slot0_active", s_act, IT_ON ? 1 : 0);
      v = s; v.en = 1'b0;
      step(v);
      chk("it_stall_remain", s_rem, IT_ON ? 2 : 0);
      step(s);
      chk("it_slot1_condex", s_ex, IT_ON ? 0 : 1);
      chk("it_slot1_remain", s_rem, IT_ON ? 2 : 0);
      step(s);
      chk("it_slot2_condex", s_ex, 1);
      chk("it_slot2_remain", s_rem, IT_ON ? 1 : 0);
      step(s);
      chk("it_done_active", s_act, 0);
      chk("it_done_remain", s_rem, 0);

      // taken branch in slot 1 of a 4-slot block flushes it
      v = s; v.its = 1'b1; v.itc = 4'h0; v.itn = 3'd4; v.itp = 4'b1111;
      step(v);
      step(s);
      chk("br_slot0_remain", s_rem, IT_ON ? 4 : 0);
      v = s; v.pcs = 1'b1;
      step(v);
      chk("br_pcsrc", s_pc, 1);
      chk("br_slot1_remain", s_rem, IT_ON ? 3 : 0);
      step(s);
      chk("br_flush_active", s_act, 0);
      chk("br_flush_remain", s_rem, 0);

      // out-of-range counts are ordinary instructions
      v = s; v.its = 1'b1; v.itn = 3'd0; v.itp = 4'b1111;
      step(v);
      chk("cnt0_regwrite", s_rw, 1);
      step(s);
      chk("cnt0_active", s_act, 0);
      v.itn = 3'd5;
      step(v);
      chk("cnt5_regwrite", s_rw, 1);
      step(s);
      chk("cnt5_active", s_act, 0);
      chk("cnt5_remain", s_rem, 0);

      // ITStart while active restarts the block
      v = s; v.its = 1'b1; v.itc = 4'h0; v.itn = 3'd4; v.itp = 4'b1111;
      step(v);
      step(s);
      v.itn = 3'd2;
      step(v);
      step(s);
      chk("abort_remain", s_rem, IT_ON ? 2 : 0);
      step(s);
      step(s);

      // randomized traffic against the model
      for (int n = 0; n < 500; n++) begin
         v.en   = ($urandom_range(0, 9) != 0);
         v.cond = 4'($urandom_range(0, 15));
         v.alu  = 4'($urandom_range(0, 15));
         v.fw   = 2'($urandom_range(0, 3));
         v.pcs  = ($urandom_range(0, 5) == 0);
         v.regw = 1'($urandom_range(0, 1));
         v.memw = 1'($urandom_range(0, 1));
         v.nowr = ($urandom_range(0, 3) == 0);
         v.bsel = 2'($urandom_range(0, 3));
         v.its  = ($urandom_range(0, 7) == 0);
         v.itc  = 4'($urandom_range(0, 15));
         v.itn  = 3'($urandom_range(0, 7));
         v.itp  = 4'($urandom_range(0, 15));
         step(v);
      end

      // drain any block, then assert reset in the middle of a cycle
      s = idle_in();
      for (int n = 0; n < ITM + 1; n++) step(s);
      v = idle_in(); v.regw = 1'b1; v.memw = 1'b1; v.pcs = 1'b1;
      drive(v);
      #2;
      chk("mid_pre_condex", int'(bus.CondEx), 1);
      reset = 1'b0;
      #1;
      chk("mid_condex", int'(bus.CondEx), 0);
      chk("mid_regwrite", int'(bus.RegWrite), 0);
      chk("mid_memwrite", int'(bus.MemWrite), 0);
      chk("mid_pcsrc", int'(bus.PCSrc), 0);
      chk("mid_flags", int'(bus.Flags), 0);
      chk("mid_itactive", int'(bus.ITActive), 0);
      model_reset();
      @(negedge clk);
      chk("mid_hold_condex", int'(bus.CondEx), 0);
      @(posedge clk); #1;
      reset = 1'b1;
      step(v);
      chk("post_rst_pcsrc", s_pc, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
